ysyx_22050535_lsu: RTL and testbench
====================================

// Module: ysyx_22050535_lsu
// PURPOSE
//  Load/store unit directly downstream of the execute unit. Takes the EXU result as the effective address, plus store data and func3.
//  Performs one byte/half/word access on a valid/ready memory bus.
//  Returns sign/zero-extended load data, or passes the EXU result through, to write-back via a valid/ready handshake.
//  Handles one transaction at a time; a 4-state FSM provides back-pressure.
// PARAMETERS
//  DATA_WIDTH  32  datapath/address width; only 32 is supported (byte-lane logic is fixed at 4 lanes)
// PORTS
//  clk             in   1   single clock, rising edge
//  rst             in   1   synchronous reset, active-high
//  in_valid        in   1   upstream op valid
//  in_ready        out  1   LSU can accept (== state IDLE)
//  in_addr         in   32  EXU result: effective address, or passthrough value
//  in_wdata        in   32  store data (src2)
//  in_func3        in   3   RV32I load/store func3
//  in_ren          in   1   op is a load
//  in_wen          in   1   op is a store (in_ren & in_wen never both 1)
//  mem_req_valid   out  1   bus request valid
//  mem_req_ready   in   1   bus accepts request
//  mem_addr        out  32  word-aligned address {addr[31:2],2'b00}
//  mem_wen         out  1   1 = write
//  mem_wdata       out  32  store data shifted into byte lanes
//  mem_wstrb       out  4   byte enables (0000 on reads)
//  mem_resp_valid  in   1   read data / write ack valid
//  mem_rdata       in   32  read word
//  mem_resp_err    in   1   bus error, qualified by mem_resp_valid
//  out_valid       out  1   result valid to write-back
//  out_ready       in   1   write-back accepts
//  out_rdata       out  32  load data, or in_addr for non-memory ops, 0 for stores
//  out_err         out  1   access error (bus error / misaligned)
// BEHAVIOUR
//  FSM: IDLE, REQ, WAIT, DONE. Reset (sync) -> IDLE; out_valid=0, mem_req_valid=0, out_rdata=0, out_err=0, all mem_* outputs 0.
//  IDLE: in_ready=1. On in_valid, latch all inputs.
//   - No ren/wen: go to DONE with out_rdata=in_addr (1-cycle bypass).
//   - Otherwise: go to REQ.
//  REQ: mem_req_valid=1. mem_addr/mem_wen/mem_wdata/mem_wstrb are registered and stable until mem_req_ready. On ready -> WAIT.
//  WAIT: mem_resp_valid is accepted only here (earliest one cycle after request acceptance; any earlier response is ignored).
//   - On response: capture data and err=mem_resp_err, go to DONE.
//  DONE: out_valid=1. out_rdata/out_err are held while !out_ready. On out_ready -> IDLE. No new op is accepted in that same cycle.
//  Min latency, accept to out_valid: bypass 1 cycle; memory op 3 cycles (ready=1, response in first WAIT cycle).
//  Lane offset: o=addr[1:0].
//   - Load func3 000 LB / 100 LBU: byte mem_rdata[8o+:8], sign-/zero-extended.
//   - Load 001 LH / 101 LHU: half mem_rdata[16*o[1]+:16], sign-/zero-extended.
//   - Load 010 LW: full word.
//   - Undefined func3 (011/110/111): treated as word access.
//  Stores:
//   - SB: wstrb=0001<<o.
//   - SH: wstrb=0011<<{o[1],0}.
//   - SW: wstrb=1111.
//   - mem_wdata = in_wdata << 8*o (byte/half). Store completes on ack; out_rdata=0.
//  Reset asserted mid-transaction: FSM -> IDLE next edge; request and response are dropped; no out_valid.
// CONFIGURATION
//  YSYX_22050535_MISALIGN_TRAP_EN defined:
//   - Misaligned half access (o[0]=1) or word access (o!=0) issues no bus request.
//   - Path is IDLE->DONE, out_err=1, out_rdata=0.
//  Undefined (default):
//   - Address is aligned down: half ignores o[0]; word ignores o.
//   - out_err comes only from mem_resp_err.
// TESTING
//  LB addr=0x8000_0003, mem_rdata=0x80AA_BBCC -> mem_addr=0x8000_0000, out_rdata=0xFFFF_FF80.
//  LHU addr=0x102, rdata=0x9234_5678 -> out_rdata=0x0000_9234; LH same -> 0xFFFF_9234.
//  SB addr=0x101, wdata=0x0000_00A5 -> wstrb=0010, mem_wdata=0x0000_A500, out_rdata=0 after ack.
//  Bypass ren=wen=0, addr=0x1234 -> out_valid next cycle, out_rdata=0x1234, no mem_req_valid.
//  Stalls: req_ready low 3 cycles, out_ready low 2 cycles -> mem_* and out_* stable, in_ready=0 throughout.
//  LW addr=0x6: TRAP_EN -> out_err=1, no request; default -> mem_addr=0x4, out_err=0.

Source files
------------

// File: rtl/ysyx_22050535_lsu.sv
// -----------------------------------------------------------------------------
// ysyx_22050535_lsu
//
// Load/store unit that sits directly after the execute unit. The EXU result is
// used as the effective address for loads and stores. For any other operation
// it is passed straight through to write-back. Only one operation is in flight
// at a time. A four-state FSM (IDLE, REQ, WAIT, DONE) provides back-pressure on
// both the upstream and the write-back handshakes.
//
// Optional feature macro: YSYX_22050535_MISALIGN_TRAP_EN
//   defined   : a misaligned half access (addr[0]=1) or word access
//               (addr[1:0]!=0) issues no bus request. The result is
//               out_err=1 with out_rdata=0, delivered one cycle after accept.
//   undefined : the access is aligned down inside the word. A half access
//               ignores addr[0] and a word access ignores addr[1:0]. out_err
//               then comes only from mem_resp_err.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  upstream handshake (ready only in IDLE)
//   in_addr         effective address, or passthrough value
//   in_wdata        store data (rs2)
//   in_func3        RV32I load/store func3
//   in_ren, in_wen  load / store select (never both set)
//   mem_req_*       bus request: registered word address, write flag,
//                   lane-shifted data and byte strobes
//   mem_resp_*      bus response: read word, error, valid
//   out_valid/ready write-back handshake
//   out_rdata       extended load data, passthrough value, or 0 for stores
//   out_err         bus error (or misalignment trap when enabled)
// -----------------------------------------------------------------------------
module ysyx_22050535_lsu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic [2:0]            in_func3,
  input  logic                  in_ren,
  input  logic                  in_wen,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic                  out_err
);

  // The byte-lane logic assumes a 32-bit word, which gives four lanes.
  localparam int LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_t;

  // func3[1:0] selects the size. The undefined encodings 011/110/111 fall
  // through to a word access.
  function automatic acc_size_t decode_size(input logic [2:0] f3);
    acc_size_t s;
    case (f3[1:0])
      2'b00:   s = SZ_BYTE;
      2'b01:   s = SZ_HALF;
      default: s = SZ_WORD;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t                  state_reg,     state_next;
  acc_size_t               size_reg,      size_next;
  logic [1:0]              off_reg,       off_next;
  logic                    sign_reg,      sign_next;
  logic                    load_reg,      load_next;
  logic [DATA_WIDTH-1:0]   mem_addr_reg,  mem_addr_next;
  logic                    mem_wen_reg,   mem_wen_next;
  logic [DATA_WIDTH-1:0]   mem_wdata_reg, mem_wdata_next;
  logic [3:0]              mem_wstrb_reg, mem_wstrb_next;
  logic [DATA_WIDTH-1:0]   out_rdata_reg, out_rdata_next;
  logic                    out_err_reg,   out_err_next;

  // ---------------------------------------------------------------------------
  // Request-side decode. This logic is only used while IDLE accepts an op.
  // ---------------------------------------------------------------------------
  acc_size_t             in_size;
  logic [1:0]            in_off;
  logic [1:0]            in_eff_off;  // lane offset after aligning down to the access size
  logic [4:0]            in_shamt;
  logic [LANES-1:0]      in_lane_hit;
  logic [DATA_WIDTH-1:0] in_wdata_lanes;
  logic                  in_is_mem;
  logic                  in_trap;

  assign in_size   = decode_size(in_func3);
  assign in_off    = in_addr[1:0];
  assign in_is_mem = in_ren | in_wen;

  always_comb begin
    in_eff_off = 2'b00;
    case (in_size)
      SZ_BYTE: in_eff_off = in_off;
      SZ_HALF: in_eff_off = {in_off[1], 1'b0};
      default: in_eff_off = 2'b00;
    endcase
  end

  assign in_shamt       = {in_eff_off, 3'b000};
  assign in_wdata_lanes = in_wdata << in_shamt;

  // A lane is enabled when it lies inside the (aligned-down) access footprint.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_strb
    localparam logic [1:0] LANE = 2'(gi);
    assign in_lane_hit[gi] = (in_size == SZ_WORD) ||
                             ((in_size == SZ_HALF) && (LANE[1] == in_off[1])) ||
                             ((in_size == SZ_BYTE) && (LANE == in_off));
  end

`ifdef YSYX_22050535_MISALIGN_TRAP_EN
  assign in_trap = in_is_mem &&
                   (((in_size == SZ_HALF) && in_off[0]) ||
                    ((in_size == SZ_WORD) && (in_off != 2'b00)));
`else
  assign in_trap = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Response-side extraction, driven by the offset and size latched at accept.
  // ---------------------------------------------------------------------------
  logic [7:0]            rd_lane [LANES];
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_value;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_rd_lane
    assign rd_lane[gi] = mem_rdata[8*gi +: 8];
  end

  assign ld_byte = rd_lane[off_reg];
  assign ld_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_value = mem_rdata;
    case (size_reg)
      SZ_BYTE: ld_value = {{(DATA_WIDTH-8){sign_reg & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_value = {{(DATA_WIDTH-16){sign_reg & ld_half[15]}}, ld_half};
      default: ld_value = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state and register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    size_next      = size_reg;
    off_next       = off_reg;
    sign_next      = sign_reg;
    load_next      = load_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wen_next   = mem_wen_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_wstrb_next = mem_wstrb_reg;
    out_rdata_next = out_rdata_reg;
    out_err_next   = out_err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          size_next = in_size;
          off_next  = in_off;
          sign_next = ~in_func3[2];
          load_next = in_ren;
          if (!in_is_mem) begin
            // Non-memory op: the EXU result goes straight to write-back.
            out_rdata_next = in_addr;
            out_err_next   = 1'b0;
            state_next     = ST_DONE;
          end else if (in_trap) begin
            out_rdata_next = '0;
            out_err_next   = 1'b1;
            state_next     = ST_DONE;
          end else begin
            // The bus fields are registered here, so they stay constant
            // throughout REQ no matter how long mem_req_ready is held low.
            mem_addr_next  = {in_addr[DATA_WIDTH-1:2], 2'b00};
            mem_wen_next   = in_wen;
            mem_wdata_next = in_wen ? in_wdata_lanes : '0;
            mem_wstrb_next = in_wen ? in_lane_hit : 4'b0000;
            state_next     = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (mem_req_ready) begin
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Responses are only looked at here. Anything seen while in REQ is
        // ignored.
        if (mem_resp_valid) begin
          out_rdata_next = load_reg ? ld_value : '0;
          out_err_next   = mem_resp_err;
          state_next     = ST_DONE;
        end
      end

      ST_DONE: begin
        // in_ready is low here, so completing the handshake never overlaps
        // with accepting the next op.
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      size_reg      <= SZ_WORD;
      off_reg       <= 2'b00;
      sign_reg      <= 1'b0;
      load_reg      <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wen_reg   <= 1'b0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= 4'b0000;
      out_rdata_reg <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      size_reg      <= size_next;
      off_reg       <= off_next;
      sign_reg      <= sign_next;
      load_reg      <= load_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wen_reg   <= mem_wen_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_wstrb_reg <= mem_wstrb_next;
      out_rdata_reg <= out_rdata_next;
      out_err_reg   <= out_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready      = (state_reg == ST_IDLE);
  assign mem_req_valid = (state_reg == ST_REQ);
  assign out_valid     = (state_reg == ST_DONE);
  assign mem_addr      = mem_addr_reg;
  assign mem_wen       = mem_wen_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign mem_wstrb     = mem_wstrb_reg;
  assign out_rdata     = out_rdata_reg;
  assign out_err       = out_err_reg;

endmodule

// File: tb/tb_ysyx_22050535_lsu.sv
// -----------------------------------------------------------------------------
// tb_ysyx_22050535_lsu
//
// Bench for the load/store unit. It runs three groups of stimulus:
//   - a table of directed vectors, each holding its expected results as
//     constants
//   - randomized operations, checked against a reference model written from
//     the access rules (size, lane offset, extension, latency)
//   - hand-written sequences that assert reset mid-transaction
// The bus responder and the write-back sink are driven inline. Both can add
// programmable stalls.
// -----------------------------------------------------------------------------
module tb_ysyx_22050535_lsu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [2:0]  in_func3;
  logic        in_ren;
  logic        in_wen;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  ysyx_22050535_lsu #(.DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_func3      (in_func3),
    .in_ren        (in_ren),
    .in_wen        (in_wen),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata     (mem_rdata),
    .mem_resp_err  (mem_resp_err),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rdata     (out_rdata),
    .out_err       (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
    logic        ren;
    logic        wen;
    logic [31:0] rdata;       // word the responder returns
    logic        err;         // error the responder returns
    int          req_stall;   // cycles mem_req_ready is held low
    int          resp_delay;  // WAIT cycles before the response
    int          out_stall;   // cycles out_ready is held low
    logic        junk;        // drive stray responses during REQ
  } op_t;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } res_t;

  typedef struct {
    op_t  op;
    res_t exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic op_t mk_op(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                                input logic r, input logic w, input logic [31:0] rd, input logic e,
                                input int rs, input int rdl, input int os, input logic j);
    op_t o;
    o.addr = a; o.wdata = wd; o.func3 = f3; o.ren = r; o.wen = w;
    o.rdata = rd; o.err = e; o.req_stall = rs; o.resp_delay = rdl; o.out_stall = os; o.junk = j;
    return o;
  endfunction

  function automatic res_t mk_res(input logic q, input logic [31:0] a, input logic wn,
                                  input logic [31:0] wd, input logic [3:0] st,
                                  input logic [31:0] rd, input logic e, input int l);
    res_t r;
    r.req = q; r.addr = a; r.wen = wn; r.wdata = wd; r.wstrb = st; r.rdata = rd; r.err = e; r.lat = l;
    return r;
  endfunction

  // Reference model built from the access rules with plain arithmetic.
  function automatic res_t model(input op_t op);
    res_t        r;
    int          size;
    int          o;
    int          eo;
    bit          is_mem;
    bit          trap;
    logic [31:0] v;
    logic [31:0] mask;
    r = mk_res(0, 0, 0, 0, 0, 0, 0, 0);
    o = int'(op.addr[1:0]);
    size = (op.func3[1:0] == 2'b00) ? 1 : (op.func3[1:0] == 2'b01) ? 2 : 4;
    is_mem = op.ren || op.wen;
    trap = 0;
`ifdef YSYX_22050535_MISALIGN_TRAP_EN
    trap = is_mem && ((o % size) != 0);
`endif
    if (!is_mem) begin
      r.rdata = op.addr;
      r.lat   = 1;
    end else if (trap) begin
      r.err = 1;
      r.lat = 1;
    end else begin
      eo      = o - (o % size);
      r.req   = 1;
      r.addr  = op.addr - 32'(o);
      r.wen   = op.wen;
      r.wstrb = op.wen ? 4'(((1 << size) - 1) << eo) : 4'b0000;
      r.wdata = op.wdata << (8 * eo);
      v = op.rdata >> (8 * eo);
      if (size < 4) begin
        mask = (32'd1 << (8 * size)) - 32'd1;
        v = v & mask;
        if (op.func3[2] == 1'b0 && v[8*size-1]) v = v | ~mask;
      end
      r.rdata = op.ren ? v : 32'd0;
      r.err   = op.err;
      r.lat   = op.req_stall + op.resp_delay + 3;
    end
    return r;
  endfunction

  function automatic res_t zero_res();
    return mk_res(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  int txn_id = 0;

  // Applies one op and plays the bus and write-back sides. It records the
  // observed request fields, result and latency, and counts any cycle where a
  // held output changes or in_ready is high while busy.
  task automatic run_op(input op_t op, output res_t ob, output int unstable,
                        output int busy_rdy, output bit tmo, output logic rdy_after);
    int cyc, req_cnt, out_cnt, wait_cnt;
    bit accepted, resp_sent, leaving, done, seen_out;
    ob = zero_res();
    unstable = 0; busy_rdy = 0; tmo = 0; rdy_after = 1'b0;
    req_cnt = 0; out_cnt = 0; wait_cnt = 0;
    accepted = 0; resp_sent = 0; leaving = 0; done = 0; seen_out = 0;

    in_addr = op.addr; in_wdata = op.wdata; in_func3 = op.func3;
    in_ren = op.ren; in_wen = op.wen; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0;
    in_addr = $urandom; in_wdata = $urandom; in_func3 = 3'($urandom);

    cyc = 1;
    while (!done && cyc <= 40) begin
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
      mem_rdata = $urandom; mem_resp_err = 1'($urandom);
      if (in_ready) busy_rdy++;
      if (mem_req_valid) begin
        if (!ob.req) begin
          ob.req = 1; ob.addr = mem_addr; ob.wen = mem_wen; ob.wdata = mem_wdata; ob.wstrb = mem_wstrb;
        end else if ({mem_addr, mem_wen, mem_wdata, mem_wstrb} !== {ob.addr, ob.wen, ob.wdata, ob.wstrb}) begin
          unstable++;
        end
        req_cnt++;
        if (op.junk) mem_resp_valid = 1'b1;
        if (req_cnt > op.req_stall) begin
          mem_req_ready = 1'b1;
          accepted = 1;
        end
      end else if (accepted && !resp_sent) begin
        if (wait_cnt == op.resp_delay) begin
          mem_resp_valid = 1'b1; mem_rdata = op.rdata; mem_resp_err = op.err;
          resp_sent = 1;
        end else begin
          wait_cnt++;
        end
      end
      if (out_valid) begin
        if (!seen_out) begin
          seen_out = 1; ob.lat = cyc; ob.rdata = out_rdata; ob.err = out_err;
        end else if ({out_rdata, out_err} !== {ob.rdata, ob.err}) begin
          unstable++;
        end
        out_cnt++;
        if (out_cnt > op.out_stall) begin
          out_ready = 1'b1;
          leaving = 1;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (leaving) done = 1;
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
    tmo = !done;
    rdy_after = in_ready;
    if (tmo) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    txn_id++;
    $display("txn %0d ren=%0d wen=%0d f3=%0d addr=%08h -> req=%0d maddr=%08h wstrb=%b wdata=%08h rdata=%08h err=%0d lat=%0d",
             txn_id, op.ren, op.wen, op.func3, op.addr, ob.req, ob.addr, ob.wstrb, ob.wdata,
             ob.rdata, ob.err, ob.lat);
  endtask

  task automatic check_op(input string tag, input op_t op, input res_t exp);
    res_t ob;
    int   unstable, busy_rdy;
    bit   tmo;
    logic rdy_after;
    run_op(op, ob, unstable, busy_rdy, tmo, rdy_after);
    chk({tag, ".timeout"}, 32'(tmo), 32'd0);
    chk({tag, ".req"}, 32'(ob.req), 32'(exp.req));
    if (exp.req) begin
      chk({tag, ".mem_addr"}, ob.addr, exp.addr);
      chk({tag, ".mem_wen"}, 32'(ob.wen), 32'(exp.wen));
      chk({tag, ".mem_wstrb"}, 32'(ob.wstrb), 32'(exp.wstrb));
      if (op.wen) chk({tag, ".mem_wdata"}, ob.wdata, exp.wdata);
    end
    chk({tag, ".out_rdata"}, ob.rdata, exp.rdata);
    chk({tag, ".out_err"}, 32'(ob.err), 32'(exp.err));
    chk({tag, ".latency"}, 32'(ob.lat), 32'(exp.lat));
    chk({tag, ".stable"}, 32'(unstable), 32'd0);
    chk({tag, ".busy_in_ready"}, 32'(busy_rdy), 32'd0);
    chk({tag, ".in_ready_after"}, 32'(rdy_after), 32'd1);
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_rdata"}, out_rdata, 32'd0);
    chk({tag, ".out_err"}, 32'(out_err), 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
    chk({tag, ".mem_wen"}, 32'(mem_wen), 32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'd0);
  endtask

  vec_t vecs[16];

  initial begin
    op_t  op;
    res_t exp;

    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_func3 = '0;
    in_ren = 1'b0; in_wen = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_rdata = '0; mem_resp_err = 1'b0; out_ready = 1'b0;

    // Directed vectors: {op, expected}.
    vecs[0]  = '{mk_op(32'h8000_0003, 0, 3'b000, 1, 0, 32'h80AA_BBCC, 0, 0, 0, 0, 0),
                 mk_res(1, 32'h8000_0000, 0, 0, 4'b0000, 32'hFFFF_FF80, 0, 3)};
    vecs[1]  = '{mk_op(32'h0000_0102, 0, 3'b101, 1, 0, 32'h9234_5678, 0, 0, 0, 0, 0),
                 mk_res(1, 32'h0000_0100, 0, 0, 4'b0000, 32'h0000_9234, 0, 3)};
    vecs[2]  = '{mk_op(32'h0000_0102, 0, 3'b001, 1, 0, 32'h9234_5678, 0, 0, 0, 0, 0),
                 mk_res(1, 32'h0000_0100, 0, 0, 4'b0000, 32'hFFFF_9234, 0, 3)};
    vecs[3]  = '{mk_op(32'h0000_0101, 32'h0000_00A5, 3'b000, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0),
                 mk_res(1, 32'h0000_0100, 1, 32'h0000_A500, 4'b0010, 32'h0, 0, 3)};
    vecs[4]  = '{mk_op(32'h0000_1234, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0),
                 mk_res(0, 0, 0, 0, 0, 32'h0000_1234, 0, 1)};
    vecs[5]  = '{mk_op(32'h0000_0040, 0, 3'b010, 1, 0, 32'h1122_3344, 0, 3, 0, 2, 0),
                 mk_res(1, 32'h0000_0040, 0, 0, 4'b0000, 32'h1122_3344, 0, 6)};
`ifdef YSYX_22050535_MISALIGN_TRAP_EN
    vecs[6]  = '{mk_op(32'h0000_0006, 0, 3'b010, 1, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 0),
                 mk_res(0, 0, 0, 0, 0, 32'h0, 1, 1)};
    vecs[12] = '{mk_op(32'h0000_0003, 0, 3'b001, 1, 0, 32'h8001_AAAA, 0, 0, 0, 0, 0),
                 mk_res(0, 0, 0, 0, 0, 32'h0, 1, 1)};
    vecs[13] = '{mk_op(32'h0000_0003, 32'h0000_ABCD, 3'b001, 0, 1, 32'h0, 0, 0, 0, 0, 0),
                 mk_res(0, 0, 0, 0, 0, 32'h0, 1, 1)};
    vecs[14] = '{mk_op(32'h0000_0002, 32'h0102_0304, 3'b010, 0, 1, 32'h0, 0, 0, 0, 0, 0),
                 mk_res(0, 0, 0, 0, 0, 32'h0, 1, 1)};
`else
    vecs[6]  = '{mk_op(32'h0000_0006, 0, 3'b010, 1, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 0),
                 mk_res(1, 32'h0000_0004, 0, 0, 4'b0000, 32'hCAFE_F00D, 0, 3)};
    vecs[12] = '{mk_op(32'h0000_0003, 0, 3'b001, 1, 0, 32'h8001_AAAA, 0, 0, 0, 0, 0),
                 mk_res(1, 32'h0000_0000, 0, 0, 4'b0000, 32'hFFFF_8001, 0, 3)};
    vecs[13] = '{mk_op(32'h0000_0003, 32'h0000_ABCD, 3'b001, 0, 1, 32'h0, 0, 0, 0, 0, 0),
                 mk_res(1, 32'h0000_0000, 1, 32'hABCD_0000, 4'b1100, 32'h0, 0, 3)};
    vecs[14] = '{mk_op(32'h0000_0002, 32'h0102_0304, 3'b010, 0, 1, 32'h0, 0, 0, 0, 0, 0),
                 mk_res(1, 32'h0000_0000, 1, 32'h0102_0304, 4'b1111, 32'h0, 0, 3)};
`endif
    vecs[7]  = '{mk_op(32'h0000_0080, 0, 3'b010, 1, 0, 32'h0000_0055, 1, 0, 1, 0, 0),
                 mk_res(1, 32'h0000_0080, 0, 0, 4'b0000, 32'h0000_0055, 1, 4)};
    vecs[8]  = '{mk_op(32'h0000_0202, 32'h1234_BEEF, 3'b001, 0, 1, 32'h0, 0, 1, 0, 1, 0),
                 mk_res(1, 32'h0000_0200, 1, 32'hBEEF_0000, 4'b1100, 32'h0, 0, 4)};
    vecs[9]  = '{mk_op(32'h0000_0300, 32'h89AB_CDEF, 3'b010, 0, 1, 32'h0, 0, 1, 2, 0, 1),
                 mk_res(1, 32'h0000_0300, 1, 32'h89AB_CDEF, 4'b1111, 32'h0, 0, 6)};
    vecs[10] = '{mk_op(32'h0000_0001, 0, 3'b100, 1, 0, 32'h1234_5678, 0, 0, 0, 0, 0),
                 mk_res(1, 32'h0000_0000, 0, 0, 4'b0000, 32'h0000_0056, 0, 3)};
    vecs[11] = '{mk_op(32'h0000_0010, 0, 3'b011, 1, 0, 32'h8765_4321, 0, 0, 0, 0, 1),
                 mk_res(1, 32'h0000_0010, 0, 0, 4'b0000, 32'h8765_4321, 0, 3)};
    vecs[15] = '{mk_op(32'h0000_0002, 0, 3'b000, 1, 0, 32'h007F_0000, 1, 2, 1, 1, 1),
                 mk_res(1, 32'h0000_0000, 0, 0, 4'b0000, 32'h0000_007F, 1, 6)};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_reset("reset");

    // Directed table
    for (int i = 0; i < 16; i++) begin
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].exp);
    end

    // Randomized ops against the reference model
    for (int n = 0; n < 150; n++) begin
      int kind;
      logic [2:0] ld_f3 [8];
      ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
      kind = $urandom_range(0, 9);
      op = mk_op($urandom, $urandom, 3'b010, 0, 0, $urandom, ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0));
      if (kind < 2) begin
        op.func3 = 3'($urandom);
      end else if (kind < 6) begin
        op.ren = 1'b1;
        op.func3 = ld_f3[$urandom_range(0, 7)];
      end else begin
        op.wen = 1'b1;
        op.func3 = 3'($urandom_range(0, 2));
      end
      exp = model(op);
      check_op($sformatf("rnd%0d", n), op, exp);
    end

    // Reset while a request is pending (reset beats a simultaneous accept)
    in_addr = 32'h0000_0044; in_func3 = 3'b010; in_ren = 1'b1; in_wen = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_ren = 1'b0;
    chk("midreq.req_valid", 32'(mem_req_valid), 32'd1);
    rst = 1'b1; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_req_ready = 1'b0;
    check_idle_reset("midreq");
    mem_resp_valid = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midreq.dropped_out_valid", 32'(out_valid), 32'd0);
    chk("midreq.dropped_in_ready", 32'(in_ready), 32'd1);

    // Reset while waiting for the response, with the response coinciding
    in_addr = 32'h0000_0048; in_func3 = 3'b010; in_ren = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_ren = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    chk("midwait.in_wait", 32'({mem_req_valid, in_ready, out_valid}), 32'd0);
    rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h2468_ACE0;
    @(posedge clk); #1;
    rst = 1'b0; mem_resp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_reset("midwait");

    // Reset while a bypass result is waiting for write-back
    in_addr = 32'h0000_5A5A; in_func3 = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("middone.out_valid", 32'(out_valid), 32'd1);
    chk("middone.out_rdata", out_rdata, 32'h0000_5A5A);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_reset("middone");

    // Recovery after the resets
    check_op("recover", vecs[0].op, vecs[0].exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
